mtimer: RTL
===========

# mtimer

Memory-mapped machine timer for the RISC-V platform: an APB slave holding a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register.
- Drives the core's `mtime` input (for `time`/`timeh` CSR reads) and its `mtimer_int` interrupt input.
- Sits on the core's APB bus alongside the RAM; the address decoder selects it via `psel`.
- Replaces the free-running bench counter and the externally driven timer interrupt.

## Interface
- `TICK_DIV`, default 1: `clk` cycles per `mtime` increment; legal range 1..65535.
- `ADDR_W`, default 12: width of `paddr`, a byte offset within the block.
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `psel` input 1: APB select.
- `penable` input 1: APB access phase.
- `pready` output 1: APB ready.
- `paddr` input ADDR_W: byte offset.
- `pwrite` input 1: write when 1.
- `pwdata` input 32: write data.
- `pwstrb` input 4: byte strobes.
- `prdata` output 32: read data.
- `pslverr` output 1: APB error.
- `mtime` output 64: current timer value.
- `mtimer_int` output 1: machine timer interrupt, level.
- `msip_int` output 1: machine software interrupt, level.

## Operation
- Register map, word offsets:
  - 0x00 MTIME_LO, 0x04 MTIME_HI: R/W.
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI: R/W.
  - 0x10 MSIP: bit 0 R/W, bits 31:1 read 0; only with `MTIMER_MSIP_EN`.
- Error responses, `pslverr`=1 in the access phase:
  - any other offset;
  - `paddr[1:0]` != 0.
  - On error: no register changes; `prdata` = 0.
- Writes honour `pwstrb` per byte; `pwstrb`=0 is a legal no-op with no error.
- Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1. With TICK_DIV=1 the tick is every cycle.
- On a tick, `mtime` increments by 1 with full 64-bit carry from LO into HI and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A write to MTIME_LO or MTIME_HI in the same cycle as a tick:
  - the written bytes take the written value;
  - unwritten bytes of that word keep their pre-increment value;
  - the other word takes its incremented value only if a carry crosses into it, computed from the old value.
  - The prescaler is never reset by writes.
- `mtimer_int` is registered as (`mtime` >= `mtimecmp`), unsigned 64-bit compare, evaluated on the post-update values.
- Software must write MTIMECMP_HI then MTIMECMP_LO. Spurious interrupts during a split write are architectural and not filtered.

## Timing
- Reset values:
  - `mtime` = 0; `mtimecmp` = all ones; prescaler = 0; MSIP = 0.
  - `mtimer_int` = 0; `msip_int` = 0.
  - `pready` = 0; `pslverr` = 0; `prdata` = 0.
- APB has zero wait states:
  - `pready` = `psel` & `penable` (combinational).
  - `prdata` and `pslverr` are valid only while `pready`=1 and are 0 otherwise.
- A write commits on the clock edge ending the access phase.
- Read data is the register value before that edge. A read of `mtime` in a tick cycle returns the old value.
- `mtime` output reflects the register directly: zero latency after the update edge.
- `mtimer_int` lags `mtime`/`mtimecmp` by exactly one cycle.
  - Example: `mtime` goes 9->10 with `mtimecmp`=10; `mtimer_int` rises one edge later.
- `msip_int` equals the MSIP register bit with zero latency.
- Reset asserted mid-transfer clears all state immediately. The partial write is lost.

## Configuration
- `MTIMER_MSIP_EN` defined:
  - MSIP register at 0x10 is implemented;
  - `msip_int` follows bit 0.
- `MTIMER_MSIP_EN` undefined:
  - offset 0x10 returns `pslverr`=1;
  - `msip_int` is tied to 0;
  - no MSIP flop exists.

## Structure
- Shared package `mtimer_pkg`:
  - offset constants `MTIMER_OFS_MTIME_LO`/`_HI`, `MTIMER_OFS_MTIMECMP_LO`/`_HI`, `MTIMER_OFS_MSIP`;
  - `MTIMECMP_RESET` = 64'hFFFF_FFFF_FFFF_FFFF.
- One sub-module, `mtimer_prescaler`: parameter TICK_DIV, ports `clk`, `rst_n`, `tick`.
- APB decode, the byte-strobe merge and the compare stay in the top module.

## Test plan
- Reset, no bus traffic, TICK_DIV=1 -> `mtime` = 100 after 100 cycles; `mtimer_int`=0 throughout.
- Write MTIMECMP_HI=0, then MTIMECMP_LO=50 -> `mtimer_int` rises one cycle after `mtime` reaches 50 and stays high.
- Write MTIME_LO=0xFFFF_FFFF and MTIME_HI=0 -> after the next tick, HI=1 and LO=0. Read HI returns 1 with `pslverr`=0.
- Write MTIME_LO with `pwstrb`=4'b0010, `pwdata`=0x0000_AB00, in a tick cycle, old LO=0x10 -> LO = 0x0000_AB10.
- Read 0x14, then read 0x02 -> `pslverr`=1 and `prdata`=0 for each; no register changes.
- With `MTIMER_MSIP_EN`: write 0x10=1 -> `msip_int`=1; write 0 -> 0. Without the macro: same write -> `pslverr`=1 and `msip_int` stays 0.

Source files
------------

// File: rtl/mtimer_pkg.sv
// Shared constants, register-select type and byte-strobe helper for the mtimer APB block.
package mtimer_pkg;

    localparam int unsigned MTIMER_OFS_MTIME_LO    = 32'h00;
    localparam int unsigned MTIMER_OFS_MTIME_HI    = 32'h04;
    localparam int unsigned MTIMER_OFS_MTIMECMP_LO = 32'h08;
    localparam int unsigned MTIMER_OFS_MTIMECMP_HI = 32'h0C;
    localparam int unsigned MTIMER_OFS_MSIP        = 32'h10;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        RegNone,
        RegMtimeLo,
        RegMtimeHi,
        RegCmpLo,
        RegCmpHi,
        RegMsip
    } mtimer_reg_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Tick generator for mtime: one-cycle pulse every TICK_DIV clocks (every cycle when TICK_DIV=1).
module mtimer_prescaler #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [15:0] cnt_q, cnt_d;

    assign tick = (cnt_q == 16'(TICK_DIV - 1));

    always_comb begin
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mtimer.sv
// APB machine timer: 64-bit mtime/mtimecmp with level timer interrupt.
// Define MTIMER_MSIP_EN to add the MSIP software-interrupt register at offset 0x10.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    output logic              pready,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              pwrite,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pwstrb,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic [63:0]       mtime,
    output logic              mtimer_int,
    output logic              msip_int
);

    logic        access;
    logic        wr_en;
    logic        tick;
    logic        mtimer_int_q;
    mtimer_reg_e reg_sel;
    logic [31:0] rd_data;
    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    mtimer_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign access  = psel & penable;
    assign pready  = access;
    assign wr_en   = access & pwrite & (reg_sel != RegNone);
    assign pslverr = access & (reg_sel == RegNone);
    assign prdata  = (access && (reg_sel != RegNone)) ? rd_data : 32'd0;

    always_comb begin
        reg_sel = RegNone;
        if (paddr[1:0] == 2'b00) begin
            if (paddr == ADDR_W'(MTIMER_OFS_MTIME_LO)) begin
                reg_sel = RegMtimeLo;
            end else if (paddr == ADDR_W'(MTIMER_OFS_MTIME_HI)) begin
                reg_sel = RegMtimeHi;
            end else if (paddr == ADDR_W'(MTIMER_OFS_MTIMECMP_LO)) begin
                reg_sel = RegCmpLo;
            end else if (paddr == ADDR_W'(MTIMER_OFS_MTIMECMP_HI)) begin
                reg_sel = RegCmpHi;
`ifdef MTIMER_MSIP_EN
            end else if (paddr == ADDR_W'(MTIMER_OFS_MSIP)) begin
                reg_sel = RegMsip;
`endif
            end
        end
    end

`ifdef MTIMER_MSIP_EN
    logic msip_q, msip_d;

    always_comb begin
        msip_d = msip_q;
        if (wr_en && (reg_sel == RegMsip) && pwstrb[0]) begin
            msip_d = pwdata[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip_q <= 1'b0;
        end else begin
            msip_q <= msip_d;
        end
    end

    assign msip_int = msip_q;
`else
    assign msip_int = 1'b0;
`endif

    always_comb begin
        rd_data = 32'd0;
        unique case (reg_sel)
            RegMtimeLo: rd_data = mtime_q[31:0];
            RegMtimeHi: rd_data = mtime_q[63:32];
            RegCmpLo:   rd_data = mtimecmp_q[31:0];
            RegCmpHi:   rd_data = mtimecmp_q[63:32];
`ifdef MTIMER_MSIP_EN
            RegMsip:    rd_data = {31'd0, msip_q};
`endif
            default:    rd_data = 32'd0;
        endcase
    end

    // The untouched word keeps its tick-incremented value, so a carry out of
    // the old LO still reaches HI when only LO is written.
    always_comb begin
        mtime_inc  = mtime_q + 64'd1;
        mtime_d    = tick ? mtime_inc : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            unique case (reg_sel)
                RegMtimeLo: mtime_d[31:0]     = strb_merge(mtime_q[31:0], pwdata, pwstrb);
                RegMtimeHi: mtime_d[63:32]    = strb_merge(mtime_q[63:32], pwdata, pwstrb);
                RegCmpLo:   mtimecmp_d[31:0]  = strb_merge(mtimecmp_q[31:0], pwdata, pwstrb);
                RegCmpHi:   mtimecmp_d[63:32] = strb_merge(mtimecmp_q[63:32], pwdata, pwstrb);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q      <= 64'd0;
            mtimecmp_q   <= MTIMECMP_RESET;
            mtimer_int_q <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            mtimer_int_q <= (mtime_q >= mtimecmp_q);
        end
    end

    assign mtime      = mtime_q;
    assign mtimer_int = mtimer_int_q;

endmodule
